sd_spi_responder: RTL and testbench

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

---
 rtl/sd_spi_responder.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_sd_spi_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_spi_responder : SPI-mode SD card responder backed by a byte memory port |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sd_spi_responder #(
  parameter int INIT_COUNT = 2,
  parameter int BUSY_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rd_data,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data,
  output logic [15:0] debug
);

  localparam logic [3:0] S_HUNT     = 4'd0;
  localparam logic [3:0] S_CMD_RX   = 4'd1;
  localparam logic [3:0] S_NCR      = 4'd2;
  localparam logic [3:0] S_RESP     = 4'd3;
  localparam logic [3:0] S_RD_GAP   = 4'd4;
  localparam logic [3:0] S_RD_TOKEN = 4'd5;
  localparam logic [3:0] S_RD_DATA  = 4'd6;
  localparam logic [3:0] S_RD_CRC   = 4'd7;
  localparam logic [3:0] S_WR_TOKEN = 4'd8;
  localparam logic [3:0] S_WR_DATA  = 4'd9;
  localparam logic [3:0] S_WR_CRC   = 4'd10;
  localparam logic [3:0] S_WR_DRESP = 4'd11;
  localparam logic [3:0] S_WR_BUSY  = 4'd12;

  localparam logic [7:0] INIT_LIM  = 8'(INIT_COUNT);
  localparam logic [8:0] BUSY_LAST = 9'(BUSY_BYTES - 1);

  logic       cs_s1_q, cs_s2_q, sclk_s1_q, sclk_s2_q, sclk_s3_q, mosi_s1_q, mosi_s2_q;
  logic [3:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic       miso_q, miso_d;
  logic [5:0] cmd_q, cmd_d;
  logic [22:0] arg_q, arg_d;
  logic [8:0] cnt_q, cnt_d;
  logic [8:0] byte_idx_q, byte_idx_d;
  logic       idle_q, idle_d, app_q, app_d;
  logic [7:0] init_cnt_q, init_cnt_d;
  logic       mem_wr_en_q, mem_wr_en_d;
  logic [7:0] mem_wr_data_q, mem_wr_data_d;

  logic       cs_act, sclk_rise, sclk_fall, byte_done;
  logic [7:0] rx_byte;

  assign cs_act    = ~cs_s2_q;
  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign rx_byte   = {rx_sr_q, mosi_s2_q};
  assign byte_done = cs_act & sclk_rise & (bit_cnt_q == 3'd7);

  assign miso        = miso_q;
  assign mem_addr    = {arg_q, byte_idx_q};
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = mem_wr_data_q;
  assign debug       = {state_q, cmd_q, idle_q, app_q, 4'b0000};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    miso_d        = miso_q;
    cmd_d         = cmd_q;
    arg_d         = arg_q;
    cnt_d         = cnt_q;
    byte_idx_d    = byte_idx_q;
    idle_d        = idle_q;
    app_d         = app_q;
    init_cnt_d    = init_cnt_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_data_d = mem_wr_data_q;

    // Advance the write address only after the strobe, so each write sees its own index.
    if (mem_wr_en_q && byte_idx_q != 9'd511) byte_idx_d = byte_idx_q + 9'd1;

    if (!cs_act) begin
      state_d   = S_HUNT;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b1;
      tx_sr_d   = 8'hFF;
    end else begin
      if (sclk_fall) begin
        miso_d  = tx_sr_q[7];
        tx_sr_d = {tx_sr_q[6:0], 1'b1};
      end
      if (sclk_rise) begin
        rx_sr_d   = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      // Each completed byte decides the next slot and loads the byte to send in it.
      if (byte_done) begin
        tx_sr_d = 8'hFF;
        case (state_q)
          S_HUNT: begin
            if (rx_byte[7:6] == 2'b01) begin
              cmd_d   = rx_byte[5:0];
              cnt_d   = 9'd0;
              state_d = S_CMD_RX;
            end
          end
          S_CMD_RX: begin
            if (cnt_q < 9'd4) begin
              arg_d = {arg_q[14:0], rx_byte};
              cnt_d = cnt_q + 9'd1;
            end else begin
              state_d = S_NCR;
            end
          end
          S_NCR: begin
            state_d = S_RESP;
            cnt_d   = 9'd0;
            case (cmd_q)
              6'd0: begin
                idle_d     = 1'b1;
                app_d      = 1'b0;
                init_cnt_d = 8'd0;
                tx_sr_d    = 8'h01;
              end
              6'd8, 6'd16: tx_sr_d = {7'd0, idle_q};
              6'd55: begin
                app_d   = 1'b1;
                tx_sr_d = {7'd0, idle_q};
              end
              6'd17, 6'd24: tx_sr_d = idle_q ? 8'h05 : 8'h00;
              6'd41: begin
                if (!app_q) begin
                  tx_sr_d = {5'd0, 1'b1, 1'b0, idle_q};
                end else if (init_cnt_q < INIT_LIM) begin
                  init_cnt_d = init_cnt_q + 8'd1;
                  tx_sr_d    = 8'h01;
                end else begin
                  idle_d  = 1'b0;
                  tx_sr_d = 8'h00;
                end
              end
              default: tx_sr_d = {5'd0, 1'b1, 1'b0, idle_q};
            endcase
          end
          S_RESP: begin
            if (cmd_q == 6'd8 && cnt_q < 9'd4) begin
              cnt_d = cnt_q + 9'd1;
              case (cnt_q[1:0])
                2'd2:    tx_sr_d = 8'h01;
                2'd3:    tx_sr_d = arg_q[7:0];
                default: tx_sr_d = 8'h00;
              endcase
            end else begin
              cnt_d      = 9'd0;
              byte_idx_d = 9'd0;
              if (cmd_q != 6'd55) app_d = 1'b0;
              if (!idle_q && cmd_q == 6'd17)      state_d = S_RD_GAP;
              else if (!idle_q && cmd_q == 6'd24) state_d = S_WR_TOKEN;
              else                                state_d = S_HUNT;
            end
          end
          S_RD_GAP: begin
            state_d = S_RD_TOKEN;
            tx_sr_d = 8'hFE;
          end
          S_RD_TOKEN: begin
            state_d    = S_RD_DATA;
            tx_sr_d    = mem_rd_data;
            byte_idx_d = 9'd1;
            cnt_d      = 9'd0;
          end
          S_RD_DATA: begin
            if (cnt_q == 9'd511) begin
              state_d = S_RD_CRC;
              cnt_d   = 9'd0;
            end else begin
              cnt_d   = cnt_q + 9'd1;
              tx_sr_d = mem_rd_data;
              if (byte_idx_q != 9'd511) byte_idx_d = byte_idx_q + 9'd1;
            end
          end
          S_RD_CRC: begin
            if (cnt_q == 9'd1) state_d = S_HUNT;
            else               cnt_d   = cnt_q + 9'd1;
          end
          S_WR_TOKEN: begin
            if (rx_byte == 8'hFE) begin
              state_d = S_WR_DATA;
              cnt_d   = 9'd0;
            end else if (rx_byte != 8'hFF) begin
              state_d = S_HUNT;
            end
          end
          S_WR_DATA: begin
            mem_wr_en_d   = 1'b1;
            mem_wr_data_d = rx_byte;
            if (cnt_q == 9'd511) begin
              state_d = S_WR_CRC;
              cnt_d   = 9'd0;
            end else begin
              cnt_d = cnt_q + 9'd1;
            end
          end
          S_WR_CRC: begin
            if (cnt_q == 9'd1) begin
              state_d = S_WR_DRESP;
              tx_sr_d = 8'h05;
            end else begin
              cnt_d = cnt_q + 9'd1;
            end
          end
          S_WR_DRESP: begin
            cnt_d = 9'd0;
            if (BUSY_BYTES == 0) begin
              state_d = S_HUNT;
            end else begin
              state_d = S_WR_BUSY;
              tx_sr_d = 8'h00;
            end
          end
          S_WR_BUSY: begin
            if (cnt_q == BUSY_LAST) begin
              state_d = S_HUNT;
            end else begin
              cnt_d   = cnt_q + 9'd1;
              tx_sr_d = 8'h00;
            end
          end
          default: state_d = S_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1_q       <= 1'b1;
      cs_s2_q       <= 1'b1;
      sclk_s1_q     <= 1'b0;
      sclk_s2_q     <= 1'b0;
      sclk_s3_q     <= 1'b0;
      mosi_s1_q     <= 1'b1;
      mosi_s2_q     <= 1'b1;
      state_q       <= S_HUNT;
      bit_cnt_q     <= 3'd0;
      rx_sr_q       <= 7'd0;
      tx_sr_q       <= 8'hFF;
      miso_q        <= 1'b1;
      cmd_q         <= 6'd0;
      arg_q         <= 23'd0;
      cnt_q         <= 9'd0;
      byte_idx_q    <= 9'd0;
      idle_q        <= 1'b1;
      app_q         <= 1'b0;
      init_cnt_q    <= 8'd0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= 8'd0;
    end else begin
      cs_s1_q       <= cs;
      cs_s2_q       <= cs_s1_q;
      sclk_s1_q     <= sclk;
      sclk_s2_q     <= sclk_s1_q;
      sclk_s3_q     <= sclk_s2_q;
      mosi_s1_q     <= mosi;
      mosi_s2_q     <= mosi_s1_q;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      miso_q        <= miso_d;
      cmd_q         <= cmd_d;
      arg_q         <= arg_d;
      cnt_q         <= cnt_d;
      byte_idx_q    <= byte_idx_d;
      idle_q        <= idle_d;
      app_q         <= app_d;
      init_cnt_q    <= init_cnt_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sd_spi_responder : directed SPI host driving sd_spi_responder            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sd_spi_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b1;
  logic        miso;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic [15:0] debug;

  int          n_vec = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  int          wr_bad = 0;
  int          rd_range_bad = 0;
  logic [31:0] exp_wr_addr = 32'h0;
  logic [7:0]  exp_wr_data = 8'h0;
  logic [7:0]  rbuf [0:7];

  always #5 clk = ~clk;

  sd_spi_responder #(.INIT_COUNT(2), .BUSY_BYTES(4)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .debug(debug)
  );

  // Memory model: read data is the low address byte, one clk after the address.
  always @(posedge clk) mem_rd_data <= mem_addr[7:0];

  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (mem_addr !== exp_wr_addr || mem_wr_data !== exp_wr_data) wr_bad++;
      exp_wr_addr++;
      wr_cnt++;
    end
    if (debug[15:12] == 4'd6 && (mem_addr < 32'h600 || mem_addr > 32'h7FF)) rd_range_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One mode-0 byte, sclk = clk/8.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (4) @(posedge clk); #1;
      rx[i] = miso;
      sclk = 1'b1;
      repeat (4) @(posedge clk); #1;
      sclk = 1'b0;
    end
  endtask

  task automatic sel();
    cs = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic desel();
    repeat (4) @(posedge clk); #1;
    cs = 1'b1;
    repeat (8) @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [5:0] c, input logic [31:0] arg, input logic [7:0] crc,
                          input int nresp);
    logic [7:0] fr [0:5];
    logic [7:0] r;
    int bad;
    bad = 0;
    fr[0] = {2'b01, c};
    fr[1] = arg[31:24];
    fr[2] = arg[23:16];
    fr[3] = arg[15:8];
    fr[4] = arg[7:0];
    fr[5] = crc;
    for (int i = 0; i < 6; i++) begin
      xfer(fr[i], r);
      if (r !== 8'hFF) bad++;
    end
    for (int k = 0; k <= nresp; k++) begin
      xfer(8'hFF, r);
      rbuf[k] = r;
    end
    check("frame_ff", bad, 0);
  endtask

  initial begin
    logic [7:0]  r;
    logic [47:0] exp8;
    int          bad;

    repeat (4) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_miso", miso, 1);
    check("rst_debug", debug, 16'h0020);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wr_data", mem_wr_data, 0);

    sel(); send_cmd(6'd0, 32'h0, 8'h95, 1);
    check("cmd0_ncr", rbuf[0], 8'hFF);
    check("cmd0_r1", rbuf[1], 8'h01);
    desel();

    sel(); send_cmd(6'd8, 32'h000001AA, 8'h87, 5);
    exp8 = 48'hFF01_0000_01AA;
    for (int k = 0; k < 6; k++) check("cmd8_resp", rbuf[k], exp8[47-8*k -: 8]);
    desel();

    sel(); send_cmd(6'd58, 32'h0, 8'h01, 1);
    check("illegal_idle", rbuf[1], 8'h05);
    desel();

    sel(); send_cmd(6'd17, 32'h3, 8'h01, 1);
    check("cmd17_idle_r1", rbuf[1], 8'h05);
    check("cmd17_idle_state", debug[15:12], 4'd0);
    desel();

    for (int i = 0; i < 3; i++) begin
      sel(); send_cmd(6'd55, 32'h0, 8'h01, 1);
      check("cmd55_r1", rbuf[1], 8'h01);
      check("app_flag", debug[4], 1);
      desel();
      sel(); send_cmd(6'd41, 32'h40000000, 8'h01, 1);
      check("acmd41_r1", rbuf[1], (i < 2) ? 8'h01 : 8'h00);
      desel();
    end
    check("idle_cleared", debug[5], 0);

    sel(); send_cmd(6'd41, 32'h0, 8'h01, 1);
    check("cmd41_noapp", rbuf[1], 8'h04);
    desel();

    sel(); send_cmd(6'd16, 32'h200, 8'h01, 1);
    check("cmd16_r1", rbuf[1], 8'h00);
    desel();

    // Block read from arg 3.
    sel(); send_cmd(6'd17, 32'h3, 8'h01, 1);
    check("rd_r1", rbuf[1], 8'h00);
    xfer(8'hFF, r); check("rd_gap", r, 8'hFF);
    xfer(8'hFF, r); check("rd_token", r, 8'hFE);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      xfer(8'hFF, r);
      if (r !== i[7:0]) bad++;
    end
    check("rd_data", bad, 0);
    xfer(8'hFF, r); check("rd_crc0", r, 8'hFF);
    xfer(8'hFF, r); check("rd_crc1", r, 8'hFF);
    xfer(8'hFF, r); check("rd_after", r, 8'hFF);
    check("rd_state", debug[15:12], 4'd0);
    check("rd_last_addr", mem_addr, 32'h7FF);
    check("rd_addr_range", rd_range_bad, 0);
    desel();

    // Block write to arg 1.
    exp_wr_addr = 32'h200; exp_wr_data = 8'hA5; wr_cnt = 0; wr_bad = 0;
    sel(); send_cmd(6'd24, 32'h1, 8'h01, 1);
    check("wr_r1", rbuf[1], 8'h00);
    xfer(8'hFF, r);
    xfer(8'hFE, r);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      xfer(8'hA5, r);
      if (r !== 8'hFF) bad++;
    end
    check("wr_data_miso", bad, 0);
    xfer(8'h12, r);
    xfer(8'h34, r);
    xfer(8'hFF, r); check("wr_dresp", r, 8'h05);
    for (int i = 0; i < 4; i++) begin
      xfer(8'hFF, r); check("wr_busy", r, 8'h00);
    end
    xfer(8'hFF, r); check("wr_after_busy", r, 8'hFF);
    desel();
    check("wr_count", wr_cnt, 512);
    check("wr_addr_data", wr_bad, 0);

    // Write aborted by cs after 100 data bytes.
    exp_wr_addr = 32'h200; exp_wr_data = 8'h5A; wr_cnt = 0; wr_bad = 0;
    sel(); send_cmd(6'd24, 32'h1, 8'h01, 1);
    check("abort_r1", rbuf[1], 8'h00);
    xfer(8'hFE, r);
    for (int i = 0; i < 100; i++) xfer(8'h5A, r);
    desel();
    check("abort_count", wr_cnt, 100);
    check("abort_addr_data", wr_bad, 0);
    check("abort_state", debug[15:12], 4'd0);
    sel(); send_cmd(6'd0, 32'h0, 8'h95, 1);
    check("abort_cmd0", rbuf[1], 8'h01);
    desel();

    // Reset in the middle of a command frame with cs low and sclk high.
    sel();
    xfer(8'h51, r);
    mosi = 1'b0;
    repeat (4) @(posedge clk); #1;
    sclk = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_debug", debug, 16'h0020);
    check("midrst_miso", miso, 1);
    sclk = 1'b0;
    cs = 1'b1;
    repeat (4) @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
